// File: rtl/serial_pkg.sv
// Shared serial-line definitions for the transmitter and the matching receiver.
// Line levels, frame state encoding and the parity helper live here so both ends agree.
package serial_pkg;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b1;
    localparam logic STOP_LEVEL  = 1'b0;
    localparam logic IDLE_LEVEL  = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/serial_data_xmit_if.sv
// Byte-in / serial-out handshake bundle: the producer (master) offers bytes, the transmitter (slave)
// answers with ready, the serial line and frame status.
interface serial_data_xmit_if;
    import serial_pkg::*;

    logic                 I_VALID;
    logic [DATA_BITS-1:0] I_DATA;
    logic                 O_READY;
    logic                 O_SERIAL_DATA;
    logic                 O_BUSY;
    logic                 O_DONE;

    modport master (
        output I_VALID,
        output I_DATA,
        input  O_READY,
        input  O_SERIAL_DATA,
        input  O_BUSY,
        input  O_DONE
    );

    modport slave (
        input  I_VALID,
        input  I_DATA,
        output O_READY,
        output O_SERIAL_DATA,
        output O_BUSY,
        output O_DONE
    );

endinterface

// File: rtl/serial_bit_timer.sv
// Bit-period counter: bit_tick marks the last cycle of each CLKS_PER_BIT-cycle bit while enabled.
// No latency beyond the count itself; clear restarts the period at 0 on the next edge.
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic enable,
    input  logic clear,
    output logic bit_tick
);

    localparam int             CW   = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Tick is not gated by clear: clear is itself derived from tick in the last STOP cycle.
    assign bit_tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/serial_data_xmit.sv
// Byte-to-serial transmitter: start, 8 data bits LSB first, parity, stop; start bit one cycle after accept.
// Ready only when idle or in the last stop cycle, so back-to-back frames run with no idle gap.
module serial_data_xmit
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic              clk,
    input  logic              rstn,
    serial_data_xmit_if.slave xif
);

    localparam int IW = $clog2(DATA_BITS);

    state_t               state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic [IW-1:0]        bit_idx_q;
    logic                 serial_q;
    logic                 busy_q;

    logic bit_tick;
    logic ready;
    logic accept;

    assign ready  = (state_q == IDLE) || ((state_q == STOP) && bit_tick);
    assign accept = xif.I_VALID && ready;

    serial_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rstn     (rstn),
        .enable   (busy_q),
        .clear    (accept),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bit_idx_q <= '0;
            serial_q  <= IDLE_LEVEL;
            busy_q    <= 1'b0;
        end else if (accept) begin
            state_q   <= START;
            shift_q   <= xif.I_DATA;
            parity_q  <= calc_parity(xif.I_DATA, PARITY_ODD);
            bit_idx_q <= '0;
            serial_q  <= START_LEVEL;
            busy_q    <= 1'b1;
        end else if (bit_tick) begin
            case (state_q)
                START: begin
                    state_q  <= DATA;
                    serial_q <= shift_q[0];
                    shift_q  <= shift_q >> 1;
                end
                DATA: begin
                    // The index parks at the last bit and hands over to parity.
                    if (bit_idx_q == IW'(DATA_BITS - 1)) begin
                        state_q  <= PARITY;
                        serial_q <= parity_q;
                    end else begin
                        bit_idx_q <= bit_idx_q + 1'b1;
                        serial_q  <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                    end
                end
                PARITY: begin
                    state_q  <= STOP;
                    serial_q <= STOP_LEVEL;
                end
                default: begin
                    state_q  <= IDLE;
                    serial_q <= IDLE_LEVEL;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign xif.O_READY       = ready;
    assign xif.O_SERIAL_DATA = serial_q;
    assign xif.O_BUSY        = busy_q;
    assign xif.O_DONE        = (state_q == STOP) && bit_tick;

endmodule

// File: tb/tb_serial_data_xmit.sv
// Bench for serial_data_xmit: three instances (1 clk/bit even, 1 clk/bit odd, 4 clk/bit even)
// against a cycle-accurate scoreboard of expected line/done/busy/ready values.
module tb_serial_data_xmit;

    logic       clk = 1'b0;
    logic       rstn;
    logic       vld  [3];
    logic [7:0] dat  [3];
    logic       ser  [3];
    logic       done [3];
    logic       busy [3];
    logic       rdy  [3];

    always #5 clk = ~clk;

    serial_data_xmit_if xif0 ();
    serial_data_xmit_if xif1 ();
    serial_data_xmit_if xif2 ();

    assign xif0.I_VALID = vld[0];
    assign xif0.I_DATA  = dat[0];
    assign xif1.I_VALID = vld[1];
    assign xif1.I_DATA  = dat[1];
    assign xif2.I_VALID = vld[2];
    assign xif2.I_DATA  = dat[2];

    assign ser[0]  = xif0.O_SERIAL_DATA;
    assign done[0] = xif0.O_DONE;
    assign busy[0] = xif0.O_BUSY;
    assign rdy[0]  = xif0.O_READY;
    assign ser[1]  = xif1.O_SERIAL_DATA;
    assign done[1] = xif1.O_DONE;
    assign busy[1] = xif1.O_BUSY;
    assign rdy[1]  = xif1.O_READY;
    assign ser[2]  = xif2.O_SERIAL_DATA;
    assign done[2] = xif2.O_DONE;
    assign busy[2] = xif2.O_BUSY;
    assign rdy[2]  = xif2.O_READY;

    serial_data_xmit #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b0)) u_dut_even1 (.clk(clk), .rstn(rstn), .xif(xif0));
    serial_data_xmit #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b1)) u_dut_odd1  (.clk(clk), .rstn(rstn), .xif(xif1));
    serial_data_xmit #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) u_dut_even4 (.clk(clk), .rstn(rstn), .xif(xif2));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc_cnt [3];
    int acc_cyc [3];

    logic [1:0] sbq      [3][$];
    logic       cap      [3][$];
    int         done_cyc [3][$];

    typedef struct {
        int          k;
        logic [7:0]  d;
        logic [10:0] frame;
    } vec_t;

    vec_t tbl [5];

    function automatic int cpb_of(input int k);
        return (k == 2) ? 4 : 1;
    endfunction

    function automatic logic odd_of(input int k);
        return (k == 1);
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d at cycle %0d: got %0h expected %0h", nm, k, cyc, act, exp);
        end
    endtask

    // Expected {line, done} for every cycle of one frame.
    function automatic void push_frame(input int k, input logic [7:0] d);
        logic [10:0] f;
        f[0]   = 1'b1;
        f[8:1] = d;
        f[9]   = (^d) ^ odd_of(k);
        f[10]  = 1'b0;
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c < cpb_of(k); c++) begin
                sbq[k].push_back({f[b], (b == 10) && (c == cpb_of(k) - 1)});
            end
        end
    endfunction

    function automatic logic [10:0] frame_at(input int k, input int off);
        logic [10:0] f;
        for (int b = 0; b < 11; b++) begin
            int idx;
            idx  = off + b * cpb_of(k);
            f[b] = (idx < cap[k].size()) ? cap[k][idx] : 1'bx;
        end
        return f;
    endfunction

    always @(negedge clk) begin : mon
        logic [1:0] e;
        logic       er;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (!rstn) begin
                sbq[k].delete();
                chk("rst_line",  k, 32'(ser[k]),  32'd0);
                chk("rst_busy",  k, 32'(busy[k]), 32'd0);
                chk("rst_done",  k, 32'(done[k]), 32'd0);
                chk("rst_ready", k, 32'(rdy[k]),  32'd1);
            end else begin
                if (sbq[k].size() != 0) begin
                    e = sbq[k].pop_front();
                    cap[k].push_back(ser[k]);
                    chk("line",  k, 32'(ser[k]),  32'(e[1]));
                    chk("done",  k, 32'(done[k]), 32'(e[0]));
                    chk("busy",  k, 32'(busy[k]), 32'd1);
                    chk("ready", k, 32'(rdy[k]),  32'(e[0]));
                    er = e[0];
                end else begin
                    chk("idle_line",  k, 32'(ser[k]),  32'd0);
                    chk("idle_done",  k, 32'(done[k]), 32'd0);
                    chk("idle_busy",  k, 32'(busy[k]), 32'd0);
                    chk("idle_ready", k, 32'(rdy[k]),  32'd1);
                    er = 1'b1;
                end
                if (done[k]) done_cyc[k].push_back(cyc);
                if (vld[k] && er) begin
                    push_frame(k, dat[k]);
                    acc_cnt[k]++;
                    acc_cyc[k] = cyc;
                end
            end
        end
    end

    task automatic wait_acc(input int k, input int n0);
        for (int t = 0; t < 100 && acc_cnt[k] == n0; t++) begin
            @(posedge clk);
            #1;
        end
        chk("accept", k, 32'(acc_cnt[k] - n0), 32'd1);
    endtask

    task automatic wait_empty(input int k);
        for (int t = 0; t < 400 && sbq[k].size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", k, 32'(sbq[k].size()), 32'd0);
    endtask

    task automatic send(input int k, input logic [7:0] d);
        int n0;
        cap[k].delete();
        @(posedge clk);
        #1;
        vld[k] = 1'b1;
        dat[k] = d;
        n0     = acc_cnt[k];
        wait_acc(k, n0);
        vld[k] = 1'b0;
        dat[k] = ~d;
        wait_empty(k);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int a1;

        tbl[0] = '{k: 0, d: 8'h01, frame: 11'h203};
        tbl[1] = '{k: 1, d: 8'h01, frame: 11'h003};
        tbl[2] = '{k: 1, d: 8'h00, frame: 11'h201};
        tbl[3] = '{k: 2, d: 8'hFF, frame: 11'h1FF};
        tbl[4] = '{k: 0, d: 8'hA5, frame: 11'h14B};

        rstn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vld[k]     = 1'b0;
            dat[k]     = 8'h00;
            acc_cnt[k] = 0;
            acc_cyc[k] = 0;
        end

        // Byte already offered during reset is taken on the first edge after release.
        vld[0] = 1'b1;
        dat[0] = 8'hA5;
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("first_accept", 0, 32'(acc_cnt[0]), 32'd1);
        vld[0] = 1'b0;
        dat[0] = 8'h00;
        wait_empty(0);
        chk("first_len",   0, 32'(cap[0].size()), 32'd11);
        chk("first_frame", 0, 32'(frame_at(0, 0)), 32'h14B);

        for (int i = 0; i < 5; i++) begin
            send(tbl[i].k, tbl[i].d);
            chk("tbl_len",   tbl[i].k, 32'(cap[tbl[i].k].size()), 32'(11 * cpb_of(tbl[i].k)));
            chk("tbl_frame", tbl[i].k, 32'(frame_at(tbl[i].k, 0)), 32'(tbl[i].frame));
        end

        // Back-to-back with valid held high.
        cap[0].delete();
        done_cyc[0].delete();
        @(posedge clk);
        #1;
        vld[0] = 1'b1;
        dat[0] = 8'h3C;
        n0 = acc_cnt[0];
        wait_acc(0, n0);
        dat[0] = 8'hC3;
        n0 = acc_cnt[0];
        wait_acc(0, n0);
        vld[0] = 1'b0;
        dat[0] = 8'h00;
        wait_empty(0);
        chk("b2b_len",    0, 32'(cap[0].size()), 32'd22);
        chk("b2b_frame0", 0, 32'(frame_at(0, 0)),  32'h079);
        chk("b2b_frame1", 0, 32'(frame_at(0, 11)), 32'h187);
        chk("b2b_ndone",  0, 32'(done_cyc[0].size()), 32'd2);
        if (done_cyc[0].size() == 2)
            chk("b2b_done_gap", 0, 32'(done_cyc[0][1] - done_cyc[0][0]), 32'd11);

        // Valid raised mid-frame is only taken in the final stop cycle.
        cap[2].delete();
        @(posedge clk);
        #1;
        vld[2] = 1'b1;
        dat[2] = 8'hFF;
        n0 = acc_cnt[2];
        wait_acc(2, n0);
        vld[2] = 1'b0;
        dat[2] = 8'h00;
        repeat (10) @(posedge clk);
        #1;
        vld[2] = 1'b1;
        dat[2] = 8'h81;
        n0 = acc_cnt[2];
        a1 = acc_cyc[2];
        wait_acc(2, n0);
        chk("busy_accept_gap", 2, 32'(acc_cyc[2] - a1), 32'd44);
        vld[2] = 1'b0;
        dat[2] = 8'h00;
        wait_empty(2);
        chk("busy_len",    2, 32'(cap[2].size()), 32'd88);
        chk("busy_frame0", 2, 32'(frame_at(2, 0)),  32'h1FF);
        chk("busy_frame1", 2, 32'(frame_at(2, 44)), 32'h103);

        // Reset asserted during data bit 3 aborts the frame at once.
        cap[0].delete();
        done_cyc[0].delete();
        @(posedge clk);
        #1;
        vld[0] = 1'b1;
        dat[0] = 8'hA5;
        n0 = acc_cnt[0];
        wait_acc(0, n0);
        vld[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("abort_midframe", 0, 32'(busy[0]), 32'd1);
        rstn = 1'b0;
        #1;
        chk("abort_line",  0, 32'(ser[0]),  32'd0);
        chk("abort_busy",  0, 32'(busy[0]), 32'd0);
        chk("abort_done",  0, 32'(done[0]), 32'd0);
        chk("abort_ready", 0, 32'(rdy[0]),  32'd1);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("abort_nodone", 0, 32'(done_cyc[0].size()), 32'd0);
        send(0, 8'h55);
        chk("post_rst_frame", 0, 32'(frame_at(0, 0)), 32'h0AB);
        chk("post_rst_ndone", 0, 32'(done_cyc[0].size()), 32'd1);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_data_xmit.md
SERIAL_DATA_XMIT -- requirements
Module: serial_data_xmit

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1: clock cycles per serial bit period, legal range 1..1024.
REQ-002 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 I_VALID  input  1  byte offered on I_DATA.
REQ-006 I_DATA  input  8  byte to transmit.
REQ-007 O_READY  output  1  transmitter can accept a byte this cycle.
REQ-008 O_SERIAL_DATA  output  1  serial line, registered.
REQ-009 O_BUSY  output  1  frame in progress.
REQ-010 O_DONE  output  1  one-cycle pulse marking frame completion.

Function
REQ-011 Frame order SHALL be: start bit (1), 8 data bits LSB first, parity bit, stop bit (0); idle line level SHALL be 0.
REQ-012 Parity SHALL be XOR of the 8 data bits when PARITY_ODD=0, and its inverse when PARITY_ODD=1.
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-014 Transitions: IDLE->START on accept; START->DATA, DATA->PARITY after the 8th bit, PARITY->STOP, each after CLKS_PER_BIT cycles; STOP->IDLE, or STOP->START on accept.
REQ-015 Accept SHALL occur on a rising edge where I_VALID && O_READY; I_DATA SHALL be captured into a shift register and parity computed at that edge.
REQ-016 O_READY SHALL be 1 in IDLE and in the final cycle of STOP, and 0 otherwise.
REQ-017 The start bit SHALL appear on O_SERIAL_DATA the cycle after accept; each bit SHALL be held exactly CLKS_PER_BIT cycles; a frame lasts 11*CLKS_PER_BIT cycles.
REQ-018 Back-to-back: accept in the last STOP cycle SHALL drive the next start bit the following cycle, with no idle gap.
REQ-019 Changes on I_DATA or I_VALID after accept SHALL NOT affect the frame in flight.
REQ-020 O_BUSY SHALL be 1 in all states except IDLE.
REQ-021 O_DONE SHALL pulse for one cycle in the last cycle of STOP, whether or not a new byte is accepted.
REQ-022 The bit-period counter SHALL count 0..CLKS_PER_BIT-1, wrap to 0 on each bit boundary, and be sized $clog2(CLKS_PER_BIT)+1.
REQ-023 The data-bit index SHALL count 0..7 and SHALL NOT wrap beyond 7.
REQ-024 O_SERIAL_DATA SHALL be 0 in IDLE.

Reset
REQ-025 While rstn=0: state=IDLE, O_SERIAL_DATA=0, O_BUSY=0, O_DONE=0, O_READY=1, and all counters and the shift register cleared.
REQ-026 Reset assertion mid-frame SHALL abort the frame immediately, with the line returning to 0 asynchronously; no O_DONE SHALL be generated.
REQ-027 The first accept SHALL be possible on the first rising edge after rstn deasserts.

Structure
REQ-028 The shared package serial_pkg SHALL hold state_t, DATA_BITS=8, START_LEVEL=1'b1, STOP_LEVEL=1'b0, and IDLE_LEVEL=1'b0, shared with the receiver.
REQ-029 Bit-period timing SHALL be in the sub-module serial_bit_timer (inputs clk, rstn, enable, clear; output bit_tick), instantiated once.

Verification
REQ-030 CLKS_PER_BIT=1, even parity, send 0xA5 -> line 1,1,0,1,0,0,1,0,1,0,0 over 11 cycles starting the cycle after accept; O_DONE on the 11th cycle.
REQ-031 Send 0x01 with even parity -> parity bit 1; same byte with PARITY_ODD=1 -> parity bit 0; 0x00 with PARITY_ODD=1 -> parity bit 1.
REQ-032 I_VALID held high with 0x3C then 0xC3 -> 22 contiguous bit cycles, start bit of 0xC3 directly after stop of 0x3C, two O_DONE pulses 11 cycles apart.
REQ-033 CLKS_PER_BIT=4, send 0xFF -> each bit held 4 cycles, frame is 44 cycles, parity 0; I_DATA toggled mid-frame has no effect.
REQ-034 rstn pulsed low during DATA bit 3 -> O_SERIAL_DATA=0 and O_BUSY=0 at once; no O_DONE; next byte 0x55 transmits correctly.
REQ-035 I_VALID asserted while O_BUSY=1 outside the final STOP cycle -> no accept, O_READY=0, frame in flight unaffected.
